// File: rtl/iq_pulse_gen.sv
// Shaped I/Q pulse generator: linear ramp up, flat hold, linear ramp down,
// eight samples per clock, with a one-deep command buffer for back-to-back pulses.
module iq_pulse_gen #(
  parameter int IQ_WIDTH   = 14,
  parameter int RAMP_LOG2  = 5,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [IQ_WIDTH-1:0]   i_cmd_i,
  input  logic [IQ_WIDTH-1:0]   i_cmd_q,
  input  logic [HOLD_WIDTH-1:0] i_cmd_hold,
  output logic [255:0]          o_QIx8,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int N = IQ_WIDTH + RAMP_LOG2;
  localparam logic [RAMP_LOG2-1:0] LAST_CYC = RAMP_LOG2'((1 << (RAMP_LOG2 - 3)) - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;

  state_t                  state_reg;
  logic [RAMP_LOG2-1:0]    cyc_reg;
  logic [HOLD_WIDTH-1:0]   hold_cnt_reg;
  logic [IQ_WIDTH-1:0]     act_i_reg, act_q_reg;
  logic                    act_loaded_reg;
  logic [IQ_WIDTH-1:0]     pend_i_reg, pend_q_reg;
  logic [HOLD_WIDTH-1:0]   pend_hold_reg;
  logic                    pend_full_reg;
  logic [255:0]            qi_reg, qi_next;
  logic                    busy_reg, done_reg;

  logic accept, ramp_end, direct_load;
  logic [N-1:0] amp_i_ext, amp_q_ext;

  assign o_cmd_ready = ~pend_full_reg;
  assign accept      = i_cmd_valid & ~pend_full_reg;
  assign ramp_end    = (cyc_reg == LAST_CYC);
  // A command skips the pending slot when the active slot is free now or frees this edge.
  assign direct_load = accept & (((state_reg == IDLE) & ~act_loaded_reg) |
                                 ((state_reg == RAMP_DOWN) & ramp_end & ~pend_full_reg));

  assign amp_i_ext = {{RAMP_LOG2{act_i_reg[IQ_WIDTH-1]}}, act_i_reg};
  assign amp_q_ext = {{RAMP_LOG2{act_q_reg[IQ_WIDTH-1]}}, act_q_reg};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [RAMP_LOG2-1:0] k_up, k;
      logic [N-1:0]         k_ext;
      logic [IQ_WIDTH-1:0]  ramp_i, ramp_q, lane_i, lane_q;

      assign k_up  = (cyc_reg << 3) + RAMP_LOG2'(gi);
      // R-1-x over RAMP_LOG2 bits is simply the bitwise complement.
      assign k     = (state_reg == RAMP_DOWN) ? ~k_up : k_up;
      assign k_ext = {{IQ_WIDTH{1'b0}}, k};

      // Low N bits of the product are exact; dropping RAMP_LOG2 LSBs is a floor shift.
      assign ramp_i = IQ_WIDTH'((amp_i_ext * k_ext) >> RAMP_LOG2);
      assign ramp_q = IQ_WIDTH'((amp_q_ext * k_ext) >> RAMP_LOG2);

      assign lane_i = (state_reg == IDLE) ? '0 : (state_reg == HOLD) ? act_i_reg : ramp_i;
      assign lane_q = (state_reg == IDLE) ? '0 : (state_reg == HOLD) ? act_q_reg : ramp_q;

      assign qi_next[32*gi +: 32] = {16'($signed(lane_q)), 16'($signed(lane_i))};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      cyc_reg        <= '0;
      hold_cnt_reg   <= '0;
      act_i_reg      <= '0;
      act_q_reg      <= '0;
      act_loaded_reg <= 1'b0;
      pend_i_reg     <= '0;
      pend_q_reg     <= '0;
      pend_hold_reg  <= '0;
      pend_full_reg  <= 1'b0;
      qi_reg         <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      qi_reg   <= qi_next;
      busy_reg <= (state_reg != IDLE);
      done_reg <= (state_reg == RAMP_DOWN) && ramp_end;

      if (direct_load) begin
        act_i_reg      <= i_cmd_i;
        act_q_reg      <= i_cmd_q;
        hold_cnt_reg   <= i_cmd_hold;
        act_loaded_reg <= 1'b1;
      end else if (accept) begin
        pend_i_reg    <= i_cmd_i;
        pend_q_reg    <= i_cmd_q;
        pend_hold_reg <= i_cmd_hold;
        pend_full_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (act_loaded_reg) begin
            state_reg <= RAMP_UP;
            cyc_reg   <= '0;
          end
        end
        RAMP_UP: begin
          if (ramp_end) begin
            cyc_reg   <= '0;
            state_reg <= (hold_cnt_reg == '0) ? RAMP_DOWN : HOLD;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        HOLD: begin
          hold_cnt_reg <= hold_cnt_reg - 1'b1;
          if (hold_cnt_reg == HOLD_WIDTH'(1)) begin
            state_reg <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (ramp_end) begin
            cyc_reg <= '0;
            if (pend_full_reg) begin
              act_i_reg     <= pend_i_reg;
              act_q_reg     <= pend_q_reg;
              hold_cnt_reg  <= pend_hold_reg;
              pend_full_reg <= 1'b0;
              state_reg     <= RAMP_UP;
            end else if (accept) begin
              state_reg <= RAMP_UP;
            end else begin
              state_reg      <= IDLE;
              act_loaded_reg <= 1'b0;
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_QIx8 = qi_reg;
  assign o_busy = busy_reg;
  assign o_done = done_reg;

endmodule

// File: doc/iq_pulse_gen.md
IQ_PULSE_GEN -- requirements
Module: iq_pulse_gen

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 14, the signed I/Q sample width per lane.
REQ-002 SHALL have parameter RAMP_LOG2, default 5, the log2 of ramp length in samples; legal range 3..10.
REQ-003 SHALL have parameter HOLD_WIDTH, default 16, the width of the hold-count field.
REQ-004 SHALL have port i_clk, input, 1, the single clock; 8 samples are produced per cycle.
REQ-005 SHALL have port i_rst, input, 1, the reset; synchronous to i_clk and active-high.
REQ-006 SHALL have port i_cmd_valid, input, 1, which marks a pulse command as valid.
REQ-007 SHALL have port o_cmd_ready, input-side handshake output, 1, indicating the command slot is free.
REQ-008 SHALL have port i_cmd_i, input, IQ_WIDTH, the signed target I amplitude.
REQ-009 SHALL have port i_cmd_q, input, IQ_WIDTH, the signed target Q amplitude.
REQ-010 SHALL have port i_cmd_hold, input, HOLD_WIDTH, the number of full-amplitude cycles.
REQ-011 SHALL have port o_QIx8, output, 256, carrying 8 lanes, with lane n I at [32n+IQ_WIDTH-1:32n] and Q at [32n+16+IQ_WIDTH-1:32n+16].
REQ-012 SHALL have port o_busy, output, 1, which is high while a pulse is being emitted.
REQ-013 SHALL have port o_done, output, 1, a one-cycle pulse on the final word of each pulse.

Function
REQ-014 SHALL define R = 2^RAMP_LOG2 samples per ramp and C = R/8 cycles per ramp.
REQ-015 SHALL implement FSM states IDLE, RAMP_UP, HOLD and RAMP_DOWN.
REQ-016 SHALL transition IDLE->RAMP_UP in the cycle after the active buffer is loaded.
REQ-017 SHALL transition RAMP_UP->HOLD after C cycles, or RAMP_UP->RAMP_DOWN when hold = 0.
REQ-018 SHALL transition HOLD->RAMP_DOWN after hold cycles.
REQ-019 SHALL transition RAMP_DOWN->RAMP_UP after C cycles if a pending command exists, giving back-to-back pulses with no zero gap; otherwise SHALL transition RAMP_DOWN->IDLE.
REQ-020 SHALL hold a 1-deep pending command buffer and drive o_cmd_ready = !pending_full.
REQ-021 SHALL complete a handshake on valid & ready at a rising edge; a command accepted while IDLE SHALL pass straight to the active slot.
REQ-022 SHALL compute sample index k = 8*cycle_in_ramp + lane for RAMP_UP and k = R-1-(8*cycle_in_ramp + lane) for RAMP_DOWN.
REQ-023 SHALL set the lane value during a ramp to (A*k) >>> RAMP_LOG2, using a signed full-width product and an arithmetic (floor) shift; no rounding and no saturation are needed because |result| <= |A|.
REQ-024 SHALL set the lane value in HOLD to A, and in IDLE to 0.
REQ-025 SHALL sign-extend bits above IQ_WIDTH within each 16-bit half.
REQ-026 SHALL register o_QIx8, so that the first RAMP_UP word appears 2 cycles after the accepting edge.
REQ-027 SHALL keep o_busy aligned with the o_QIx8 words that belong to a pulse.
REQ-028 SHALL assert o_done aligned with the last RAMP_DOWN word, where lane 7 has k=0.
REQ-029 SHALL produce a total pulse length of 2C + hold cycles.
REQ-030 SHALL make hold counter wrap impossible: the counter is HOLD_WIDTH wide, loaded then decremented to 0.
REQ-031 SHALL ignore i_cmd_* while i_cmd_valid is low, and SHALL capture nothing when ready is low.

Reset
REQ-032 SHALL, on i_rst high at a rising edge, set FSM=IDLE, empty the pending buffer, clear counters, and set o_QIx8=0, o_busy=0, o_done=0 and o_cmd_ready=1 from the next cycle.
REQ-033 SHALL abort a pulse in progress on reset mid-pulse, with output 0 the next cycle; commands presented during reset SHALL NOT be accepted.

Verification
REQ-034 SHALL verify single pulse (RAMP_LOG2=5): I=4096, Q=0, hold=2 -> 10 busy cycles; word0 I lanes 0,128,...,896; words 4-5 all 4096; word6 lanes 3968..3072; word9 lanes 896..0 with o_done high; Q=0 throughout.
REQ-035 SHALL verify negative amplitude: Q=-8192, I=0, hold=0 -> word0 Q lane1 = -256, lane7 = -1792; 8 busy cycles; bits 30:29 of each lane equal the sign.
REQ-036 SHALL verify back-to-back: a second command accepted during the first pulse's HOLD -> ready low until the second pulse starts; the first RAMP_DOWN is followed immediately by RAMP_UP (lane0=0) with no idle cycle; exactly two o_done pulses.
REQ-037 SHALL verify backpressure: a third command held valid while pending is full -> not accepted until ready rises; no command lost or duplicated.
REQ-038 SHALL verify reset mid-RAMP_UP: i_rst for 1 cycle -> o_QIx8=0, o_busy=0, no o_done, and the pending command discarded.
REQ-039 SHALL verify a minimal ramp (RAMP_LOG2=3), hold=0, A=1000 -> 2-cycle pulse; word0 lanes 0,125,...,875; word1 lanes 875..0.
